seq_stage_ctrl: RTL and testbench
=================================

SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum cycles spent in MEMORY waiting for mem_ready.
REQ-002 SHALL have parameter CNT_W, default 32, meaning the width of instr_count.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-005 SHALL have port start, input, 1, which begins execution from IDLE.
REQ-006 SHALL have port icode, input, 4, the fetched instruction code, valid during FETCH.
REQ-007 SHALL have port instr_valid, input, 1, meaning fetch decoded a legal instruction.
REQ-008 SHALL have port imem_error, input, 1, the instruction-memory address fault.
REQ-009 SHALL have port mem_ready, input, 1, the data-memory access-complete handshake.
REQ-010 SHALL have port dmem_error, input, 1, the data-memory fault, qualified by mem_ready.
REQ-011 SHALL have ports fetch_en, decode_en, exec_en, mem_en, wb_en and pc_en, each output, 1, the per-stage enables.
REQ-012 SHALL have port cc_we, output, 1, the condition-code register write strobe.
REQ-013 SHALL have port stat, output, 3, the Y86 status: AOK=1, HLT=2, ADR=3, INS=4.
REQ-014 SHALL have port busy, output, 1, high in any state except IDLE and HALT.
REQ-015 SHALL have port instr_count, output, CNT_W, the count of retired instructions.

Function
REQ-016 SHALL implement an FSM with states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD and HALT.
REQ-017 SHALL derive each stage enable as a Moore decode of the state register, high in exactly one matching state: fetch_en in FETCH, decode_en in DECODE, exec_en in EXECUTE, wb_en in WRITEBACK, pc_en in PCUPD.
REQ-018 SHALL transition IDLE->FETCH when start=1, and otherwise remain in IDLE.
REQ-019 SHALL evaluate the following in FETCH, in priority order:
- imem_error -> HALT with stat=ADR;
- instr_valid=0 -> HALT with stat=INS;
- icode=0 -> HALT with stat=HLT;
- otherwise -> DECODE.
REQ-020 SHALL latch icode in FETCH and use the latched value through PCUPD.
REQ-021 SHALL transition DECODE->EXECUTE->MEMORY unconditionally, one cycle each.
REQ-022 SHALL assert cc_we for exactly one cycle, in EXECUTE, only when the latched icode=6 (OPq); cc_we SHALL be 0 for all other icodes.
REQ-023 SHALL treat icode 4, 5, 8, 9, A and B as memory instructions.
REQ-024 SHALL, for a memory instruction, hold mem_en=1 in MEMORY until mem_ready=1, then:
- if dmem_error=1 in that cycle -> HALT with stat=ADR;
- otherwise -> WRITEBACK.
REQ-025 SHALL go to HALT with stat=ADR when a memory instruction has waited MEM_TIMEOUT cycles in MEMORY without mem_ready.
REQ-026 SHALL, for a non-memory instruction, spend one cycle in MEMORY with mem_en=0 and ignore mem_ready and dmem_error.
REQ-027 SHALL transition WRITEBACK->PCUPD->FETCH, one cycle each.
REQ-028 SHALL increment instr_count in PCUPD, saturating at all-ones.
REQ-029 SHALL retire a non-memory instruction in 6 cycles, FETCH through PCUPD.
REQ-030 SHALL retire a memory instruction in 6+N cycles, where N is the number of mem_ready=0 cycles spent in MEMORY.
REQ-031 SHALL exit HALT only via rst; while in HALT, all enables and cc_we SHALL be 0, and stat and instr_count SHALL hold.
REQ-032 SHALL NOT assert wb_en or pc_en for a faulting instruction.
REQ-033 SHALL ignore start in every state except IDLE.

Reset
REQ-034 SHALL, when rst=1 at a rising edge (including mid-instruction or during a MEMORY wait), enter IDLE, clear the wait counter and the latched icode, and drive stat=AOK, instr_count=0 and all enables, cc_we and busy to 0.
REQ-035 SHALL give rst priority over start and over all fault inputs in the same cycle.

Verification
REQ-036 SHALL cover: rst, then start pulse, icode=6, instr_valid=1, errors 0 -> cc_we high exactly in cycle 3 after FETCH, pc_en in cycle 6, instr_count=1, stat=1.
REQ-037 SHALL cover: icode=5 with mem_ready low for 3 cycles -> mem_en high 4 cycles, retire in 9 cycles, cc_we never high.
REQ-038 SHALL cover: icode=4 with mem_ready never asserted -> HALT after 16 MEMORY cycles, stat=3, wb_en and pc_en never high.
REQ-039 SHALL cover: fetch icode=0 after 2 retired instructions -> stat=2, busy=0, instr_count=2, and start pulses ignored thereafter.
REQ-040 SHALL cover: instr_valid=0 together with imem_error=1 in FETCH -> stat=3 (ADR takes priority).
REQ-041 SHALL cover: rst asserted during a MEMORY wait -> IDLE next cycle, stat=1, instr_count=0, mem_en=0.

Source files
------------

// File: rtl/seq_stage_ctrl.sv
// Multi-cycle Y86-style stage sequencer: steps one instruction through
// FETCH..PCUPD, raises per-stage enables and tracks status and retire count.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start
// FETCH     | sample icode/fault inputs, latch icode
// DECODE    | decode stage enable
// EXECUTE   | execute stage; condition codes written for OPq
// MEMORY    | data-memory access (memory instrs wait for mem_ready)
// WRITEBACK | register write-back
// PCUPD     | PC update; instruction retires here
// HALT      | stopped on halt/fault; left only through rst
module seq_stage_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             exec_en,
    output logic             mem_en,
    output logic             wb_en,
    output logic             pc_en,
    output logic             cc_we,
    output logic [2:0]       stat,
    output logic             busy,
    output logic [CNT_W-1:0] instr_count
);

    localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);
    // Down-counter preset so that terminal count (0) coincides with the
    // last allowed MEMORY cycle.
    localparam logic [TMR_W-1:0] TMR_INIT = TMR_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE,
        S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         icode_q, icode_d;
    logic [2:0]         stat_q, stat_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_mem;

    // Memory-class decode of the latched instruction code.
    always_comb begin
        case (icode_q)
            4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem = 1'b1;
            default:                            is_mem = 1'b0;
        endcase
    end

    // State and datapath registers; rst overrides everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            icode_q <= 4'h0;
            stat_q  <= STAT_AOK;
            tmr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            icode_q <= icode_d;
            stat_q  <= stat_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and Moore stage enables.
    always_comb begin
        state_d   = state_q;
        icode_d   = icode_q;
        stat_d    = stat_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        fetch_en  = 1'b0;
        decode_en = 1'b0;
        exec_en   = 1'b0;
        mem_en    = 1'b0;
        wb_en     = 1'b0;
        pc_en     = 1'b0;
        cc_we     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_FETCH;
            end
            S_FETCH: begin
                fetch_en = 1'b1;
                icode_d  = icode;
                if (imem_error) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else if (icode == 4'h0) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                decode_en = 1'b1;
                state_d   = S_EXECUTE;
            end
            S_EXECUTE: begin
                exec_en = 1'b1;
                cc_we   = (icode_q == 4'h6);
                tmr_d   = TMR_INIT;
                state_d = S_MEMORY;
            end
            S_MEMORY: begin
                if (is_mem) begin
                    mem_en = 1'b1;
                    // A completing handshake wins over the timeout in the
                    // same cycle.
                    if (mem_ready) begin
                        if (dmem_error) begin
                            state_d = S_HALT;
                            stat_d  = STAT_ADR;
                        end else begin
                            state_d = S_WRITEBACK;
                        end
                    end else if (tmr_q == '0) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        tmr_d = tmr_q - TMR_W'(1);
                    end
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                wb_en   = 1'b1;
                state_d = S_PCUPD;
            end
            S_PCUPD: begin
                pc_en   = 1'b1;
                state_d = S_FETCH;
                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q != S_IDLE) && (state_q != S_HALT);
    assign stat        = stat_q;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Bench for seq_stage_ctrl: a driver issues instructions and pushes the
// expected outcome per instruction into a queue; a negedge monitor pops an
// entry whenever the DUT retires (pc_en) or halts (busy falls) and compares.
module tb_seq_stage_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [3:0]       icode = 4'h0;
    logic             instr_valid = 1'b0;
    logic             imem_error = 1'b0;
    logic             mem_ready = 1'b0;
    logic             dmem_error = 1'b0;
    logic             fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_we;
    logic [2:0]       stat;
    logic             busy;
    logic [CNT_W-1:0] instr_count;

    seq_stage_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .icode(icode),
        .instr_valid(instr_valid), .imem_error(imem_error),
        .mem_ready(mem_ready), .dmem_error(dmem_error),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en),
        .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en), .cc_we(cc_we),
        .stat(stat), .busy(busy), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit halt;
        int stat;
        int cycles;
        int cc;
        int cc_at;
        int mem;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   model_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit mem_class(input int c);
        return (c == 4) || (c == 5) || (c == 8) || (c == 9) || (c == 10) || (c == 11);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitor ----------------
    int   cur_cyc = 0, cur_cc = 0, cur_cc_at = 0, cur_mem = 0, cur_wbpc = 0;
    bit   prev_busy = 1'b0;
    bit   pend = 1'b0;
    int   pend_cnt = 0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            pend      = 1'b0;
            cur_cyc   = 0;
        end else begin
            if (pend) begin
                check("count_after_retire", instr_count, pend_cnt);
                pend = 1'b0;
            end
            if (fetch_en) begin
                cur_cyc = 1; cur_cc = 0; cur_cc_at = 0; cur_mem = 0; cur_wbpc = 0;
            end else if (busy) begin
                cur_cyc++;
            end
            if (cc_we) begin cur_cc++; cur_cc_at = cur_cyc; end
            if (mem_en) cur_mem++;
            if (wb_en || pc_en) cur_wbpc++;
            if (pc_en || (prev_busy && !busy)) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", 0, 1);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_is_halt", !busy, mon_e.halt);
                    check("cc_we_count", cur_cc, mon_e.cc);
                    check("cc_we_cycle", cur_cc_at, mon_e.cc_at);
                    check("mem_en_cycles", cur_mem, mon_e.mem);
                    if (pc_en) begin
                        check("retire_cycles", cur_cyc, mon_e.cycles);
                        pend     = 1'b1;
                        pend_cnt = mon_e.cnt;
                    end else begin
                        check("halt_stat", stat, mon_e.stat);
                        check("halt_count", instr_count, mon_e.cnt);
                        check("halt_no_wb_pc", cur_wbpc, 0);
                        check("halt_outputs_zero",
                              {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_we}, 0);
                    end
                end
            end
            prev_busy = busy;
        end
    end

    // ---------------- driver ----------------
    task automatic do_reset();
        rst = 1'b1; start = 1'b0; mem_ready = 1'b0; dmem_error = 1'b0;
        tick(); tick();
        rst = 1'b0;
        model_cnt = 0;
        check("sb_empty_at_reset", sb.size(), 0);
    endtask

    // Issue one instruction: wait for FETCH, drive it, predict the outcome,
    // then play the memory handshake (nwait low cycles, then ready + derr).
    task automatic run_instr(input int ic, input bit valid, input bit ierr,
                             input int nwait, input bit derr, output bit halted);
        bit   seen = 1'b0;
        exp_t e;
        for (int i = 0; i < 64 && !seen; i++) begin
            tick();
            start      = 1'b0;
            mem_ready  = 1'b0;
            dmem_error = 1'($urandom_range(0, 1));
            if (fetch_en) seen = 1'b1;
        end
        if (!seen) begin
            check("fetch_timeout", 0, 1);
            halted = 1'b1;
            return;
        end
        icode = 4'(ic); instr_valid = valid; imem_error = ierr;

        e.halt = 1'b0; e.stat = 1; e.cycles = 0; e.cc = 0; e.cc_at = 0; e.mem = 0;
        if (ierr)          begin e.halt = 1'b1; e.stat = 3; end
        else if (!valid)   begin e.halt = 1'b1; e.stat = 4; end
        else if (ic == 0)  begin e.halt = 1'b1; e.stat = 2; end
        else begin
            if (ic == 6) begin e.cc = 1; e.cc_at = 3; end
            if (mem_class(ic)) begin
                if (nwait >= MEM_TIMEOUT) begin
                    e.halt = 1'b1; e.stat = 3; e.mem = MEM_TIMEOUT;
                end else begin
                    e.mem = nwait + 1;
                    if (derr) begin e.halt = 1'b1; e.stat = 3; end
                    else e.cycles = 6 + nwait;
                end
            end else begin
                e.cycles = 6;
            end
        end
        if (!e.halt) model_cnt++;
        e.cnt = model_cnt;
        sb.push_back(e);
        halted = e.halt;

        tick();
        // Later stages must use the latched icode, so scramble the inputs.
        icode = 4'($urandom_range(0, 15));
        instr_valid = 1'($urandom_range(0, 1));
        imem_error  = 1'($urandom_range(0, 1));
        start       = 1'($urandom_range(0, 1));
        if (ierr || !valid || ic == 0) return;
        tick();
        tick();
        if (mem_class(ic)) begin
            for (int k = 0; k < MEM_TIMEOUT; k++) begin
                mem_ready  = (k >= nwait);
                dmem_error = mem_ready ? derr : 1'($urandom_range(0, 1));
                if (mem_ready || k == MEM_TIMEOUT - 1) break;
                tick();
            end
        end else begin
            mem_ready  = 1'($urandom_range(0, 1));
            dmem_error = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic finish_prog();
        bit stopped = 1'b0;
        for (int i = 0; i < 64 && !stopped; i++) begin
            tick();
            mem_ready = 1'b0;
            start     = 1'b0;
            if (!busy) stopped = 1'b1;
        end
        check("halt_reached", stopped, 1);
        tick(); tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit h;
        bit seen;
        int ic, r, nw;

        // Reset state and IDLE hold without start
        do_reset();
        check("reset_stat", stat, 1);
        check("reset_count", instr_count, 0);
        check("reset_busy", busy, 0);
        check("reset_outputs",
              {fetch_en, decode_en, exec_en, mem_en, wb_en, pc_en, cc_we}, 0);
        repeat (3) tick();
        check("idle_hold", busy, 0);

        // OPq, load with 3 wait cycles, then halt; start ignored in HALT
        start = 1'b1;
        run_instr(6, 1, 0, 0, 0, h);
        run_instr(5, 1, 0, 3, 0, h);
        run_instr(0, 1, 0, 0, 0, h);
        finish_prog();
        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            tick();
            check("halt_start_busy", busy, 0);
            check("halt_start_stat", stat, 2);
            check("halt_start_count", instr_count, 2);
        end
        start = 1'b0;

        // Memory timeout
        do_reset();
        start = 1'b1;
        run_instr(4, 1, 0, 99, 0, h);
        finish_prog();
        check("timeout_stat", stat, 3);

        // imem_error beats instr_valid=0
        do_reset();
        start = 1'b1;
        run_instr(1, 1, 0, 0, 0, h);
        run_instr(3, 0, 1, 0, 0, h);
        finish_prog();
        check("adr_priority_stat", stat, 3);

        // rst during a MEMORY wait, with start and faults asserted alongside
        do_reset();
        start = 1'b1;
        run_instr(2, 1, 0, 0, 0, h);
        seen = 1'b0;
        for (int i = 0; i < 32 && !seen; i++) begin
            tick();
            start = 1'b0; mem_ready = 1'b0;
            if (fetch_en) seen = 1'b1;
        end
        check("rst_test_fetch_seen", seen, 1);
        icode = 4'h4; instr_valid = 1'b1; imem_error = 1'b0;
        tick(); tick(); tick(); tick();
        check("rst_test_mem_wait", mem_en, 1);
        rst = 1'b1; start = 1'b1; mem_ready = 1'b1; dmem_error = 1'b1; imem_error = 1'b1;
        tick();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_stat", stat, 1);
        check("rst_mid_count", instr_count, 0);
        check("rst_mid_mem_en", mem_en, 0);
        rst = 1'b0; start = 1'b0; mem_ready = 1'b0; dmem_error = 1'b0; imem_error = 1'b0;
        model_cnt = 0;
        tick();
        check("rst_then_idle", busy, 0);

        // Randomized programs
        for (int p = 0; p < 25; p++) begin
            do_reset();
            start = 1'b1;
            h = 1'b0;
            for (int n = 0; n < 8 && !h; n++) begin
                r  = $urandom_range(0, 99);
                ic = $urandom_range(1, 15);
                nw = ($urandom_range(0, 9) == 0) ? MEM_TIMEOUT : $urandom_range(0, 6);
                if (r < 4)       run_instr(ic, 1'($urandom_range(0, 1)), 1, 0, 0, h);
                else if (r < 8)  run_instr(ic, 0, 0, 0, 0, h);
                else if (r < 12) run_instr(0, 1, 0, 0, 0, h);
                else             run_instr(ic, 1, 0, nw, ($urandom_range(0, 9) == 0), h);
            end
            if (!h) run_instr(0, 1, 0, 0, 0, h);
            finish_prog();
        end

        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
